// File: rtl/k12a_pkg.sv
// Shared types and LCD command constants for the k12a LCD sequencer.
package k12a_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4
  } lcd_seq_state_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Clear (0x01) and home (0x02/0x03) are the only instructions with only bits [1:0] set.
  function automatic logic lcd_needs_long_exec(input logic rs, input logic [7:0] cmd);
    localparam logic [7:0] LongMask = LCD_CMD_CLEAR | LCD_CMD_HOME;
    return !rs && ((cmd | LongMask) == LongMask);
  endfunction

endpackage

// File: rtl/k12a_lcd_sequencer.sv
// HD44780-style LCD write sequencer: setup, enable pulse, hold and execution wait.
// Define LCD_NIBBLE_MODE_EN for the 4-bit interface (two nibble transfers per byte).
module k12a_lcd_sequencer
  import k12a_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES     = 1,
  parameter int unsigned PULSE_CYCLES     = 4,
  parameter int unsigned HOLD_CYCLES      = 1,
  parameter int unsigned EXEC_CYCLES      = 40,
  parameter int unsigned LONG_EXEC_CYCLES = 1600
) (
  input  logic       cpu_clock,
  input  logic       reset_n,
  input  logic       xfer_req,
  input  logic       xfer_rs,
  input  logic [7:0] xfer_data,
  input  logic       overrun_clr,
  output logic       busy,
  output logic       overrun,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int unsigned Max01 = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned Max2  = (Max01 > HOLD_CYCLES) ? Max01 : HOLD_CYCLES;
  localparam int unsigned Max3  = (Max2 > EXEC_CYCLES) ? Max2 : EXEC_CYCLES;
  localparam int unsigned MaxCy = (Max3 > LONG_EXEC_CYCLES) ? Max3 : LONG_EXEC_CYCLES;
  localparam int unsigned CW    = $clog2(MaxCy + 1);

  localparam logic [CW-1:0] SetupLoad = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PulseLoad = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HoldLoad  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ExecLoad  = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] LongLoad  = CW'(LONG_EXEC_CYCLES - 1);

  lcd_seq_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           overrun_q, overrun_d;
  logic           rs_q, rs_d;
  logic           en_q, en_d;
  logic [7:0]     data_q, data_d;
  logic [7:0]     cmd_byte;

`ifdef LCD_NIBBLE_MODE_EN
  logic [7:0] byte_q, byte_d;
  logic       nib_q, nib_d;
  assign cmd_byte = byte_q;
`else
  assign cmd_byte = data_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rs_d      = rs_q;
    data_d    = data_q;
    overrun_d = overrun_q;
`ifdef LCD_NIBBLE_MODE_EN
    byte_d    = byte_q;
    nib_d     = nib_q;
`endif

    if (overrun_clr) overrun_d = 1'b0;
    if (xfer_req && (state_q != IDLE)) overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (xfer_req) begin
          rs_d    = xfer_rs;
          state_d = SETUP;
          cnt_d   = SetupLoad;
`ifdef LCD_NIBBLE_MODE_EN
          data_d  = {xfer_data[7:4], 4'h0};
          byte_d  = xfer_data;
          nib_d   = 1'b0;
`else
          data_d  = xfer_data;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = PulseLoad;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = EXEC;
          cnt_d   = lcd_needs_long_exec(rs_q, cmd_byte) ? LongLoad : ExecLoad;
`ifdef LCD_NIBBLE_MODE_EN
          // First nibble done: go straight back to SETUP with the low nibble.
          if (!nib_q) begin
            state_d = SETUP;
            cnt_d   = SetupLoad;
            data_d  = {byte_q[3:0], 4'h0};
            nib_d   = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
    en_d   = (state_d == PULSE);
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      rs_q      <= 1'b0;
      en_q      <= 1'b0;
      data_q    <= 8'h00;
`ifdef LCD_NIBBLE_MODE_EN
      byte_q    <= 8'h00;
      nib_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      rs_q      <= rs_d;
      en_q      <= en_d;
      data_q    <= data_d;
`ifdef LCD_NIBBLE_MODE_EN
      byte_q    <= byte_d;
      nib_q     <= nib_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign lcd_data = data_q;

endmodule

// File: tb/tb_k12a_lcd_sequencer.sv
// Randomized scoreboard bench for k12a_lcd_sequencer (honours LCD_NIBBLE_MODE_EN).
module tb_k12a_lcd_sequencer;

  localparam int S  = 1;
  localparam int P  = 4;
  localparam int H  = 1;
  localparam int E  = 40;
  localparam int LE = 1600;
`ifdef LCD_NIBBLE_MODE_EN
  localparam bit NIB = 1'b1;
`else
  localparam bit NIB = 1'b0;
`endif

  logic       cpu_clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       xfer_req = 1'b0;
  logic       xfer_rs = 1'b0;
  logic [7:0] xfer_data = 8'h00;
  logic       overrun_clr = 1'b0;
  logic       busy, overrun, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  k12a_lcd_sequencer dut (
    .cpu_clock  (cpu_clock),
    .reset_n    (reset_n),
    .xfer_req   (xfer_req),
    .xfer_rs    (xfer_rs),
    .xfer_data  (xfer_data),
    .overrun_clr(overrun_clr),
    .busy       (busy),
    .overrun    (overrun),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .lcd_data   (lcd_data)
  );

  always #5 cpu_clock = ~cpu_clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         rs;
    logic [7:0] data;
    int         len;
  } xact_t;

  xact_t exp_q[$];

  // Reference model: remaining busy cycles, overrun flag, last latched bus values.
  int         remain = 0;
  bit         ovr_m = 1'b0;
  bit         last_rs = 1'b0;
  logic [7:0] last_data = 8'h00;
  bit         mon_en = 1'b0;

  function automatic int total_len(input bit rs, input logic [7:0] d);
    int ex;
    ex = (!rs && d <= 8'h03) ? LE : E;
    return NIB ? 2 * (S + P + H) + ex : S + P + H + ex;
  endfunction

  task automatic cycle(input bit req, input bit rs, input logic [7:0] d, input bit clr);
    @(negedge cpu_clock);
    check("busy", busy, remain != 0);
    check("overrun", overrun, ovr_m);
    check("lcd_rw", lcd_rw, 0);
    if (remain == 0) begin
      check("idle_lcd_data", lcd_data, last_data);
      check("idle_lcd_rs", lcd_rs, last_rs);
      check("idle_lcd_en", lcd_en, 0);
    end
    xfer_req    = req;
    xfer_rs     = rs;
    xfer_data   = d;
    overrun_clr = clr;
    @(posedge cpu_clock);
    if (req && remain == 0) begin
      remain = total_len(rs, d);
      exp_q.push_back('{rs: rs, data: d, len: remain});
      last_rs   = rs;
      last_data = NIB ? {d[3:0], 4'h0} : d;
      if (clr) ovr_m = 1'b0;
    end else begin
      if (req) ovr_m = 1'b1;
      else if (clr) ovr_m = 1'b0;
      if (remain > 0) remain--;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: measures each busy window and the enable pulses inside it.
  bit         prev_busy = 1'b0;
  bit         prev_en = 1'b0;
  int         busy_cnt;
  int         np;
  int         p_len[2];
  int         p_start[2];
  logic [7:0] p_data[2];
  bit         p_rs[2];

  always @(negedge cpu_clock) begin
    if (mon_en) begin
      if (busy) begin
        if (!prev_busy) begin
          busy_cnt = 0;
          np = 0;
        end
        busy_cnt++;
      end
      if (lcd_en && !prev_en) begin
        if (np < 2) begin
          p_data[np]  = lcd_data;
          p_rs[np]    = lcd_rs;
          p_start[np] = busy_cnt;
          p_len[np]   = 0;
        end
        np++;
      end
      if (lcd_en && np >= 1 && np <= 2) begin
        p_len[np-1]++;
        check("pulse_data_stable", lcd_data, p_data[np-1]);
        check("pulse_busy", busy, 1);
      end
      if (!busy && prev_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xact", 1, 0);
        end else begin
          xact_t x;
          x = exp_q.pop_front();
          check("busy_len", busy_cnt, x.len);
          check("pulse_count", np, NIB ? 2 : 1);
          check("pulse0_rs", p_rs[0], x.rs);
          check("pulse0_len", p_len[0], P);
          check("pulse0_start", p_start[0], S + 1);
          if (NIB) begin
            check("pulse0_data", p_data[0], {x.data[7:4], 4'h0});
            check("pulse1_data", p_data[1], {x.data[3:0], 4'h0});
            check("pulse1_rs", p_rs[1], x.rs);
            check("pulse1_len", p_len[1], P);
            check("pulse1_start", p_start[1], 2 * S + P + H + 1);
          end else begin
            check("pulse0_data", p_data[0], x.data);
          end
        end
      end
      prev_busy = busy;
      prev_en   = lcd_en;
    end
  end

  initial begin
    int guard;
    int t;
    bit saw_en;

    #12;
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_lcd_en", lcd_en, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_data", lcd_data, 8'h00);
    check("rst_lcd_rw", lcd_rw, 0);
    @(negedge cpu_clock);
    reset_n = 1'b1;

    // Reset in the middle of an enable pulse.
    @(negedge cpu_clock);
    xfer_req = 1'b1; xfer_rs = 1'b1; xfer_data = 8'h41;
    @(negedge cpu_clock);
    xfer_req = 1'b0;
    check("mid_latch_data", lcd_data, NIB ? 8'h40 : 8'h41);
    saw_en = 1'b0;
    guard = 0;
    while (!saw_en && guard < 20) begin
      @(negedge cpu_clock);
      saw_en = lcd_en;
      guard++;
    end
    check("mid_saw_pulse", saw_en, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_lcd_en", lcd_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_lcd_data", lcd_data, 8'h00);
    check("mid_rst_lcd_rs", lcd_rs, 0);
    @(negedge cpu_clock);
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Directed transfers.
    cycle(1'b1, 1'b1, 8'h41, 1'b0); idle(60);
    cycle(1'b1, 1'b0, 8'h01, 1'b0); idle(1620);
    cycle(1'b1, 1'b0, 8'h06, 1'b0); idle(60);

    // Overrun 10 cycles after the first request, then clear.
    cycle(1'b1, 1'b1, 8'h41, 1'b0); idle(9);
    cycle(1'b1, 1'b1, 8'h42, 1'b0); idle(50);
    cycle(1'b0, 1'b0, 8'h00, 1'b1); idle(3);

    // Set and clear in the same cycle: set wins.
    cycle(1'b1, 1'b1, 8'h33, 1'b0);
    cycle(1'b1, 1'b1, 8'h44, 1'b1); idle(60);
    // Accept together with clear.
    cycle(1'b1, 1'b1, 8'h55, 1'b1); idle(60);

    // Back-to-back on the first idle edge, then one edge too early.
    t = total_len(1'b1, 8'h41);
    cycle(1'b1, 1'b1, 8'h41, 1'b0); idle(t);
    cycle(1'b1, 1'b1, 8'h5A, 1'b0); idle(t - 1);
    cycle(1'b1, 1'b1, 8'h66, 1'b0); idle(3);
    cycle(1'b0, 1'b0, 8'h00, 1'b1); idle(3);

    // Randomized traffic.
    repeat (6000) begin
      bit         req, rs, clr;
      logic [7:0] d;
      req = ($urandom_range(0, 24) == 0);
      rs  = $urandom_range(0, 1);
      d   = 8'($urandom);
      if ($urandom_range(0, 9) == 0) d = 8'($urandom_range(0, 3));
      clr = ($urandom_range(0, 19) == 0);
      cycle(req, rs, d, clr);
    end

    guard = 0;
    while (remain > 0 && guard < 5000) begin
      idle(1);
      guard++;
    end
    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
